// File: rtl/hazard_controller.sv
// hazard_controller: pipeline sequencing for the 5-stage RISC-V core.
//   Inputs : register addresses of D/E/M/W, pipelined control (RegWrite,
//            ResultSrc, MemWriteM, PCSrcE) and the data-memory ack.
//   Outputs: ForwardAE/ForwardBE operand selects, Stall*/Flush* enables for
//            the pipeline registers, mem_err timeout pulse and a free-running
//            count of cycles in which the PC was held.
module hazard_controller #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic [1:0]       ResultSrcM,
  input  logic             MemWriteM,
  input  logic             PCSrcE,
  input  logic             dmem_ack,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  // wcnt never exceeds TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
  localparam int unsigned      WCNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic mem_acc;
  logic mem_stall;
  logic lw_stall;

  assign mem_acc = MemWriteM || (ResultSrcM == 2'b01);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    cnt_d   = StallF ? cnt_q + CNT_W'(1) : cnt_q;
    case (state_q)
      S_IDLE: begin
        if (mem_acc && !dmem_ack) begin
          state_d = S_WAIT;
          wcnt_d  = WCNT_W'(1);
        end
      end
      S_WAIT: begin
        if (dmem_ack) begin
          state_d = S_IDLE;
          wcnt_d  = '0;
        end else if (wcnt_q == WCNT_LAST) begin
          state_d = S_ERR;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      S_ERR: begin
        // A late ack here is dropped; the access is already abandoned.
        state_d = S_IDLE;
        wcnt_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ForwardAE = 2'b01;

    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ForwardBE = 2'b01;

    lw_stall  = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                ((RdE == Rs1D) || (RdE == Rs2D));
    mem_stall = ((state_q == S_IDLE) && mem_acc && !dmem_ack) ||
                ((state_q == S_WAIT) && !dmem_ack);

    // A memory stall freezes every stage; load-use and branch flushes are
    // suppressed and re-evaluate once the held D/E contents move again.
    if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b1;
    end else begin
      StallF = lw_stall;
      StallD = lw_stall;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = PCSrcE;
      FlushE = lw_stall || PCSrcE;
      FlushW = 1'b0;
    end

    mem_err      = (state_q == S_ERR);
    stall_cycles = cnt_q;
  end

endmodule
